// File: rtl/motion_sequencer.sv
// motion_sequencer: closed-loop point-to-point move controller for one H-bridge
// channel. Ramps a signed 8-bit velocity command toward the target position and
// pulses done once the shaft has settled inside the tolerance window.
module motion_sequencer #(
    parameter int POS_W      = 16,
    parameter int VMAX       = 100,
    parameter int VMIN       = 20,
    parameter int DECEL_DIST = 256,
    parameter int TOL        = 2,
    parameter int RAMP_DIV   = 1000,
    parameter int SETTLE_CYC = 50000
) (
    input  logic                    cclk,
    input  logic                    rstb,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic signed [POS_W-1:0] cmd_target,
    input  logic                    abort,
    input  logic signed [POS_W-1:0] pos,
    output logic signed [7:0]       velocity,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted
);
    localparam int EW = POS_W + 1;
    localparam int PW = $clog2(RAMP_DIV);
    localparam int SW = $clog2(SETTLE_CYC + 1);

    localparam logic [EW-1:0] TOL_V       = EW'(TOL);
    localparam logic [EW-1:0] DECEL_V     = EW'(DECEL_DIST);
    localparam logic [6:0]    VMAX_V      = 7'(VMAX);
    localparam logic [6:0]    VMIN_V      = 7'(VMIN);
    localparam logic [PW-1:0] RAMP_LAST   = PW'(RAMP_DIV - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP, S_SETTLE} state_t;

    state_t                  state, state_nxt;
    logic signed [POS_W-1:0] target, target_nxt;
    logic                    dir, dir_nxt;
    logic                    abort_pend, pend_nxt;
    logic [6:0]              mag, mag_nxt, goal;
    logic [PW-1:0]           pre_cnt;
    logic [SW-1:0]           settle_cnt, settle_nxt;
    logic                    done_nxt, aborted_nxt;
    logic signed [EW-1:0]    err, acc_err;
    logic [EW-1:0]           abs_err;
    logic                    err_neg, in_tol, far, tick, accept;
    logic [7:0]              vel_mag;

    // Error is one bit wider than the operands so target - pos can never wrap.
    assign err     = {target[POS_W-1], target} - {pos[POS_W-1], pos};
    assign acc_err = {cmd_target[POS_W-1], cmd_target} - {pos[POS_W-1], pos};
    assign err_neg = err[EW-1];
    assign abs_err = err_neg ? -err : err;
    assign in_tol  = (abs_err <= TOL_V);
    assign far     = (abs_err > DECEL_V);

    assign tick      = (pre_cnt == RAMP_LAST);
    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign accept    = cmd_ready && cmd_valid;

    // Next-state, goal magnitude and completion decode.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_nxt   = state;
        target_nxt  = target;
        dir_nxt     = dir;
        pend_nxt    = abort_pend;
        settle_nxt  = '0;
        goal        = '0;
        done_nxt    = 1'b0;
        aborted_nxt = aborted;
        unique case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    target_nxt = cmd_target;
                    dir_nxt    = acc_err[EW-1];
                    state_nxt  = S_RUN;
                end
            end
            S_RUN: begin
                goal = far ? VMAX_V : VMIN_V;
                if (abort) begin
                    pend_nxt  = 1'b1;
                    state_nxt = S_STOP;
                end else if (in_tol || (err_neg != dir)) begin
                    // Either arrived or overshot; both brake to zero first.
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (mag == '0) begin
                    if (abort || abort_pend) begin
                        state_nxt   = S_IDLE;
                        done_nxt    = 1'b1;
                        aborted_nxt = 1'b1;
                        pend_nxt    = 1'b0;
                    end else if (in_tol) begin
                        state_nxt = S_SETTLE;
                    end else begin
                        dir_nxt   = err_neg;
                        state_nxt = S_RUN;
                    end
                end else if (abort) begin
                    pend_nxt = 1'b1;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_nxt   = S_IDLE;
                    done_nxt    = 1'b1;
                    aborted_nxt = 1'b1;
                end else if (!in_tol) begin
                    dir_nxt   = err_neg;
                    state_nxt = S_RUN;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_nxt   = S_IDLE;
                    done_nxt    = 1'b1;
                    aborted_nxt = 1'b0;
                end else begin
                    settle_nxt = settle_cnt + SW'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Ramp: magnitude moves one step toward the goal only on a prescaler tick.
    always_comb begin
        mag_nxt = mag;
        if (tick) begin
            if (mag < goal)      mag_nxt = mag + 7'd1;
            else if (mag > goal) mag_nxt = mag - 7'd1;
        end
    end

    assign vel_mag = {1'b0, mag_nxt};

    // State, ramp and output registers; velocity tracks the next mag/dir so it
    // changes in the same cycle as the internal magnitude.
    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            state      <= S_IDLE;
            target     <= '0;
            dir        <= 1'b0;
            abort_pend <= 1'b0;
            mag        <= '0;
            pre_cnt    <= '0;
            settle_cnt <= '0;
            velocity   <= '0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state      <= state_nxt;
            target     <= target_nxt;
            dir        <= dir_nxt;
            abort_pend <= pend_nxt;
            mag        <= mag_nxt;
            pre_cnt    <= (accept || tick) ? '0 : pre_cnt + PW'(1);
            settle_cnt <= settle_nxt;
            velocity   <= dir_nxt ? -vel_mag : vel_mag;
            done       <= done_nxt;
            aborted    <= aborted_nxt;
        end
    end

endmodule

// File: tb/tb_motion_sequencer.sv
// tb_motion_sequencer: directed and random moves against a behavioural model;
// every velocity change and done pulse is matched against a queued expectation.
module tb_motion_sequencer;
    localparam int POS_W      = 16;
    localparam int VMAX       = 10;
    localparam int VMIN       = 2;
    localparam int DECEL_DIST = 20;
    localparam int TOL        = 1;
    localparam int RAMP_DIV   = 4;
    localparam int SETTLE_CYC = 8;

    logic                    cclk = 1'b0;
    logic                    rstb = 1'b0;
    logic                    cmd_valid = 1'b0;
    logic                    abort = 1'b0;
    logic signed [POS_W-1:0] cmd_target = '0;
    logic signed [POS_W-1:0] pos = '0;
    logic                    cmd_ready, busy, done, aborted;
    logic signed [7:0]       velocity;

    motion_sequencer #(
        .POS_W(POS_W), .VMAX(VMAX), .VMIN(VMIN), .DECEL_DIST(DECEL_DIST),
        .TOL(TOL), .RAMP_DIV(RAMP_DIV), .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .cclk(cclk), .rstb(rstb), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_target(cmd_target), .abort(abort), .pos(pos), .velocity(velocity),
        .busy(busy), .done(done), .aborted(aborted)
    );

    initial forever #5 cclk = ~cclk;

    typedef struct {
        int cyc;
        int vel;
        bit done;
        bit ab;
    } rec_t;

    rec_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    bit   sb_en = 1'b0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: cycle %0d got %0d required %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: move phases described directly from the sequencing rules.
    typedef enum {MV_IDLE, MV_DRIVE, MV_BRAKE, MV_HOLD} mv_t;
    mv_t mv = MV_IDLE;
    int  m_target = 0, m_mag = 0, m_hold = 0, m_tick_ref = 0, m_prev_vel = 0;
    bit  m_dir = 0, m_pend = 0, m_aborted = 0;
    int  cur, err, aerr, goal, vel;
    bit  neg, tick, fin;
    rec_t rec;

    initial begin
        forever begin
            @(posedge cclk or negedge rstb);
            if (!rstb) begin
                mv = MV_IDLE; m_mag = 0; m_dir = 0; m_pend = 0; m_hold = 0;
                m_aborted = 0; m_prev_vel = 0; m_tick_ref = cyc;
            end else begin
                cur  = cyc;
                err  = m_target - pos;
                aerr = (err < 0) ? -err : err;
                neg  = (err < 0);
                tick = ((cur - m_tick_ref) % RAMP_DIV) == RAMP_DIV - 1;
                fin  = 0;
                goal = 0;
                case (mv)
                    MV_IDLE: if (cmd_valid) begin
                        m_target   = cmd_target;
                        m_dir      = (m_target - pos) < 0;
                        m_tick_ref = cur + 1;
                        mv         = MV_DRIVE;
                    end
                    MV_DRIVE: begin
                        goal = (aerr > DECEL_DIST) ? VMAX : VMIN;
                        if (abort) begin
                            m_pend = 1; mv = MV_BRAKE;
                        end else if (aerr <= TOL || neg != m_dir) begin
                            mv = MV_BRAKE;
                        end
                    end
                    MV_BRAKE: begin
                        if (m_mag == 0) begin
                            if (m_pend || abort) begin
                                mv = MV_IDLE; fin = 1; m_aborted = 1; m_pend = 0;
                            end else if (aerr <= TOL) begin
                                mv = MV_HOLD; m_hold = 0;
                            end else begin
                                m_dir = neg; mv = MV_DRIVE;
                            end
                        end else if (abort) begin
                            m_pend = 1;
                        end
                    end
                    MV_HOLD: begin
                        if (abort) begin
                            mv = MV_IDLE; fin = 1; m_aborted = 1;
                        end else if (aerr > TOL) begin
                            m_dir = neg; mv = MV_DRIVE;
                        end else if (m_hold == SETTLE_CYC - 1) begin
                            mv = MV_IDLE; fin = 1; m_aborted = 0;
                        end else begin
                            m_hold++;
                        end
                    end
                    default: mv = MV_IDLE;
                endcase
                if (tick) begin
                    if (goal > m_mag)      m_mag++;
                    else if (goal < m_mag) m_mag--;
                end
                vel = m_dir ? -m_mag : m_mag;
                cyc = cur + 1;
                if (sb_en && (vel != m_prev_vel || fin)) begin
                    rec.cyc = cyc; rec.vel = vel; rec.done = fin; rec.ab = m_aborted;
                    sb_q.push_back(rec);
                end
                m_prev_vel = vel;
            end
        end
    end

    // Monitor: any velocity change or done pulse consumes one expectation.
    logic signed [7:0] mon_prev = '0;
    rec_t              got;
    initial begin
        forever begin
            @(negedge cclk);
            if (sb_en && (velocity !== mon_prev || done === 1'b1)) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected: cycle %0d velocity %0d done %0b, no output required",
                             cyc, velocity, done);
                end else begin
                    got = sb_q.pop_front();
                    check("out_cycle", cyc, got.cyc);
                    check("velocity", velocity, got.vel);
                    check("done", done, got.done);
                    check("aborted", aborted, got.ab);
                end
            end
            mon_prev = velocity;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge cclk);
    endtask

    task automatic send(input int tgt);
        for (int i = 0; i < 500 && !cmd_ready; i++) @(negedge cclk);
        check("ready_before_send", cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_target = POS_W'(tgt);
        @(negedge cclk);
        cmd_valid = 1'b0;
        check("busy_after_accept", busy, 1);
        check("ready_low_after_accept", cmd_ready, 0);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) @(negedge cclk);
        check("idle_within_budget", busy, 0);
    endtask

    task automatic mid_reset();
        sb_en = 1'b0;
        @(posedge cclk);
        #2 rstb = 1'b0;
        #1;
        check("rst_velocity", velocity, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge cclk);
        @(negedge cclk);
        sb_q.delete();
        rstb  = 1'b1;
        sb_en = 1'b1;
    endtask

    int tgt, segs, sel;

    initial begin
        cycles(3);
        check("reset_velocity", velocity, 0);
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_aborted", aborted, 0);
        rstb  = 1'b1;
        sb_en = 1'b1;

        // Cruise up, decel window, arrival and settle.
        pos = '0;
        send(1000);
        cycles(60);
        pos = 16'sd990;
        cycles(40);
        pos = 16'sd1000;
        wait_idle(100);

        // Reverse move; command while busy is ignored; abort at full speed.
        pos = '0;
        send(-50);
        cycles(20);
        cmd_valid  = 1'b1;
        cmd_target = 16'sd500;
        @(negedge cclk);
        cmd_valid = 1'b0;
        check("ready_low_while_busy", cmd_ready, 0);
        cycles(30);
        abort = 1'b1;
        wait_idle(100);
        abort = 1'b0;

        // Already in tolerance: fixed latency to done, aborted clears.
        send(0);
        wait_idle(40);

        // Reset in the middle of a move.
        send(300);
        cycles(25);
        mid_reset();

        // Overshoot and return.
        pos = '0;
        send(100);
        cycles(50);
        pos = 16'sd130;
        cycles(100);
        pos = 16'sd100;
        wait_idle(200);

        // Randomised moves with position jumps, near-tolerance wobble and aborts.
        for (int it = 0; it < 25; it++) begin
            tgt = int'($urandom_range(0, 600)) - 300;
            pos = POS_W'(int'($urandom_range(0, 200)) - 100);
            send(tgt);
            segs = int'($urandom_range(1, 4));
            for (int s = 0; s < segs; s++) begin
                cycles(int'($urandom_range(5, 60)));
                sel = int'($urandom_range(0, 3));
                if (sel == 0) begin
                    pos = POS_W'(tgt + int'($urandom_range(0, 6)) - 3);
                end else if (sel == 1) begin
                    pos = POS_W'(int'($urandom_range(0, 800)) - 400);
                end else if (sel == 2) begin
                    abort = 1'b1;
                    cycles(int'($urandom_range(1, 3)));
                    abort = 1'b0;
                end
            end
            abort = 1'b0;
            pos   = POS_W'(tgt);
            wait_idle(400);
        end

        cycles(5);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/motion_sequencer.md
# motion_sequencer

Closed-loop point-to-point move controller for one H-bridge channel. Accepts a target position over a valid/ready handshake and compares it against the live encoder position count. Produces a ramped, signed 8-bit velocity command that feeds the `velocity` input of a `motor_driver` instance. Signals completion once the shaft has settled inside a tolerance window; one instance is used per motor channel.

## Interface
- `POS_W`, 16: width of the position count and target (signed two's complement)
- `VMAX`, 100: cruise velocity magnitude, 1..127
- `VMIN`, 20: approach velocity magnitude inside the decel window, 1..VMAX
- `DECEL_DIST`, 256: \|err\| at or below which the goal magnitude drops from VMAX to VMIN
- `TOL`, 2: \|err\| at or below which the target counts as reached
- `RAMP_DIV`, 1000: cycles per ramp tick, ≥2; each tick changes the magnitude by at most 1
- `SETTLE_CYC`, 50000: consecutive in-tolerance cycles required before done, ≥1

Ports:
- `cclk`  in  1  system clock; all state is on the rising edge
- `rstb`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  move request
- `cmd_ready`  out  1  high only in IDLE
- `cmd_target`  in  POS_W  signed target; captured on the cycle `cmd_valid && cmd_ready`
- `abort`  in  1  level; ramps the motor to 0 and ends the move
- `pos`  in  POS_W  signed encoder position count, synchronous to `cclk`
- `velocity`  out  8  signed command to `motor_driver`; negative means reverse
- `busy`  out  1  high whenever not in IDLE
- `done`  out  1  one-cycle pulse on return to IDLE
- `aborted`  out  1  registered with `done`; high if the move ended by abort; holds until the next `done`

## Operation
- err = target − pos, computed at POS_W+1 bits so it never overflows; \|err\| is taken at the same width.
- Internal state: unsigned `mag` (0..VMAX) and direction bit `dir` (1 = negative). `velocity` = dir ? −mag : mag, registered.
- Ramp prescaler:
  - Counts 0..RAMP_DIV−1 and wraps.
  - Cleared on command accept.
  - Tick is the cycle where count = RAMP_DIV−1.
  - On a tick, mag steps 1 toward goal: mag<goal gives +1, mag>goal gives −1, otherwise unchanged.
  - mag changes only on ticks.
- States:
  - IDLE: mag=0, cmd_ready=1. On accept: latch target and dir=sign(err) against the new target; go to RUN.
  - RUN: goal = VMAX if \|err\|>DECEL_DIST, else VMIN.
    - abort: STOP with the abort pending flag set.
    - \|err\|≤TOL: STOP.
    - sign(err)≠dir with \|err\|>TOL (overshoot): STOP.
  - STOP: goal=0. When mag=0:
    - abort pending: IDLE, done=1, aborted=1.
    - \|err\|≤TOL: SETTLE.
    - otherwise: relatch dir=sign(err) and go to RUN.
  - SETTLE: mag=0.
    - Settle counter starts at 0 and increments each in-tolerance cycle.
    - In tolerance with counter = SETTLE_CYC−1: IDLE, done=1, aborted=0.
    - \|err\|>TOL: relatch dir, go to RUN, counter cleared.
    - abort: IDLE, done=1, aborted=1.
- `abort` in IDLE is ignored. `cmd_valid` outside IDLE is ignored; no command is queued.
- abort takes priority over every other transition in the same cycle.

## Timing
- Reset values: velocity=0, cmd_ready=1, busy=0, done=0, aborted=0, state=IDLE, all counters 0. Reset mid-move zeroes `velocity` immediately (asynchronously).
- Accept at cycle N: busy=1 and cmd_ready=0 at N+1. First ramp tick is at N+RAMP_DIV, so velocity=±1 from N+RAMP_DIV+1.
- Accelerating from 0 to VMAX takes VMAX·RAMP_DIV cycles, and decelerating back to 0 takes the same.
- Command already in tolerance at accept (cycle N): RUN at N+1, STOP at N+2, SETTLE at N+3, done high at N+3+SETTLE_CYC.
- `done` and `aborted` update in the same cycle that `busy` falls. A new command can be accepted in that same cycle.

## Test plan
Parameters for all scenarios: RAMP_DIV=4, VMAX=10, VMIN=2, DECEL_DIST=20, TOL=1, SETTLE_CYC=8.

1. Assert rstb low mid-cycle -> velocity=0, cmd_ready=1, busy=0, done=0 immediately.
2. Hold pos=0, send target=1000 -> velocity steps 1,2,…,10 once every 4 cycles, reaches 10 at 40 cycles after accept, and holds.
3. Continuing from 2, set pos=990 -> velocity falls to 2 in 32 cycles. Then set pos=1000 -> 0 after 8 cycles, 8 SETTLE cycles, one-cycle done with aborted=0.
4. Hold pos=0, send target=−50 -> velocity −1…−10. Pulse cmd_valid while busy -> no effect.
5. Assert abort at velocity=10 -> ramps to 0 in 40 cycles, then done=1 with aborted=1; a subsequent normal move returns aborted=0.
6. Overshoot: send target=100 and let velocity reach 10, then set pos=130 -> ramps to 0, then velocity goes negative down to −10. Set pos=100 -> settles and done.
